forward_ctrl_unit: RTL and testbench

FORWARD_CTRL_UNIT -- requirements
Module: forward_ctrl_unit

---
 rtl/forward_ctrl_unit.sv | 102 ++++++++++
 tb/tb_forward_ctrl_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/forward_ctrl_unit.sv
// Forwarding-select and load-use stall controller for a 5-stage pipeline.
// Optional stall statistics counter enabled by defining FWD_STALL_STATS_EN.
module forward_ctrl_unit #(
  parameter int NB_REG   = 5,
  parameter int NB_COUNT = 16
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                valid_id_i,
  input  logic [NB_REG-1:0]   rs_id_i,
  input  logic [NB_REG-1:0]   rt_id_i,
  input  logic [NB_REG-1:0]   rd_id_i,
  input  logic                regwrite_id_i,
  input  logic                memread_id_i,
  input  logic                flush_i,
  output logic [1:0]          sel_a_o,
  output logic [1:0]          sel_b_o,
  output logic                stall_o,
  output logic [NB_COUNT-1:0] stall_count_o
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic [NB_REG-1:0] rd;
  } entry_t;

  entry_t     ex_q, mem_q, wb_q;
  entry_t     ex_d;
  logic [1:0] sel_a_q, sel_b_q, sel_a_d, sel_b_d;
  logic       ex_fwd, mem_fwd, hazard, bubble;

  // Only real, register-writing, non-r0 entries may supply a value.
  assign ex_fwd  = ex_q.valid  && ex_q.regwrite  && (ex_q.rd  != '0);
  assign mem_fwd = mem_q.valid && mem_q.regwrite && (mem_q.rd != '0);

  assign hazard  = valid_id_i && ex_fwd && ex_q.memread &&
                   ((ex_q.rd == rs_id_i) || (ex_q.rd == rt_id_i));
  assign stall_o = hazard && !flush_i;
  assign bubble  = stall_o || flush_i || !valid_id_i;

  always_comb begin
    ex_d    = '0;
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (!bubble) begin
      ex_d.valid    = 1'b1;
      ex_d.regwrite = regwrite_id_i;
      ex_d.memread  = memread_id_i;
      ex_d.rd       = rd_id_i;
      // EX match checked first so the newest producer wins.
      if (ex_fwd && (ex_q.rd == rs_id_i))        sel_a_d = SEL_EXM;
      else if (mem_fwd && (mem_q.rd == rs_id_i)) sel_a_d = SEL_MWB;
      if (ex_fwd && (ex_q.rd == rt_id_i))        sel_b_d = SEL_EXM;
      else if (mem_fwd && (mem_q.rd == rt_id_i)) sel_b_d = SEL_MWB;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
    end else if (enable_i) begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign sel_a_o = sel_a_q;
  assign sel_b_o = sel_b_q;

`ifdef FWD_STALL_STATS_EN
  logic [NB_COUNT-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (stall_o && (count_q != '1)) count_d = count_q + NB_COUNT'(1);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i)      count_q <= '0;
    else if (enable_i) count_q <= count_d;
  end

  assign stall_count_o = count_q;
`else
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// Scoreboard bench for forward_ctrl_unit: instruction-history reference model, queued expectations.
module tb_forward_ctrl_unit;
  localparam int NB_REG   = 5;
  localparam int NB_COUNT = 16;

  logic                clock_i = 1'b0;
  logic                reset_i = 1'b0;
  logic                enable_i = 1'b0;
  logic                valid_id_i = 1'b0;
  logic [NB_REG-1:0]   rs_id_i = '0, rt_id_i = '0, rd_id_i = '0;
  logic                regwrite_id_i = 1'b0, memread_id_i = 1'b0, flush_i = 1'b0;
  logic [1:0]          sel_a_o, sel_b_o;
  logic                stall_o;
  logic [NB_COUNT-1:0] stall_count_o;

  forward_ctrl_unit #(.NB_REG(NB_REG), .NB_COUNT(NB_COUNT)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
    .valid_id_i(valid_id_i), .rs_id_i(rs_id_i), .rt_id_i(rt_id_i),
    .rd_id_i(rd_id_i), .regwrite_id_i(regwrite_id_i),
    .memread_id_i(memread_id_i), .flush_i(flush_i),
    .sel_a_o(sel_a_o), .sel_b_o(sel_b_o), .stall_o(stall_o),
    .stall_count_o(stall_count_o)
  );

  always #5 clock_i = ~clock_i;

  // Issued-instruction history, newest first: [0] is in EX, [1] in MEM, [2] in WB.
  typedef struct { bit v; bit rw; bit mr; int rd; } instr_t;
  instr_t hist[$];

  typedef struct { bit stall; int sel_a; int sel_b; int cnt; string tag; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int m_sel_a  = 0, m_sel_b = 0, m_cnt = 0;
  bit last_stall = 0;
`ifdef FWD_STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit writes(int age, int r);
    if (r == 0 || age >= hist.size()) return 0;
    return hist[age].v && hist[age].rw && hist[age].rd == r;
  endfunction

  function automatic int src_sel(int r);
    if (writes(0, r)) return 1;
    if (writes(1, r)) return 2;
    return 0;
  endfunction

  // Drive one cycle of ID inputs, advance the model and queue the expectation.
  task automatic drive(string tag, bit rst, bit en, bit v, int rs, int rt, int rd,
                       bit rw, bit mr, bit fl);
    exp_t   e;
    instr_t ins;
    bit     load_dep, issue;
    @(posedge clock_i);
    #1;
    reset_i = ~rst; enable_i = en; valid_id_i = v;
    rs_id_i = NB_REG'(rs); rt_id_i = NB_REG'(rt); rd_id_i = NB_REG'(rd);
    regwrite_id_i = rw; memread_id_i = mr; flush_i = fl;

    load_dep = v && hist.size() > 0 && hist[0].mr && (writes(0, rs) || writes(0, rt));
    e.stall  = load_dep && !fl;
    last_stall = e.stall && en && !rst;
    if (rst) begin
      hist.delete();
      m_sel_a = 0; m_sel_b = 0; m_cnt = 0;
    end else if (en) begin
      issue = v && !e.stall && !fl;
      m_sel_a = issue ? src_sel(rs) : 0;
      m_sel_b = issue ? src_sel(rt) : 0;
      if (STATS && e.stall && m_cnt != (1 << NB_COUNT) - 1) m_cnt++;
      ins.v = issue; ins.rw = rw; ins.mr = mr; ins.rd = rd;
      hist.push_front(ins);
      if (hist.size() > 3) void'(hist.pop_back());
    end
    e.sel_a = m_sel_a; e.sel_b = m_sel_b; e.cnt = m_cnt; e.tag = tag;
    sb.push_back(e);
  endtask

  // Monitor: stall_o sampled mid-cycle, registered outputs after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock_i);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, ".stall"}, int'(stall_o), int'(e.stall));
        @(posedge clock_i);
        #2;
        chk({e.tag, ".sel_a"}, int'(sel_a_o), e.sel_a);
        chk({e.tag, ".sel_b"}, int'(sel_b_o), e.sel_b);
        chk({e.tag, ".count"}, int'(stall_count_o), e.cnt);
      end
    end
  end

  initial begin
    int k;
    bit rst, en, v, rw, mr, fl;
    int rs, rt, rd;
    // reset
    drive("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("rst1", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("idle", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // add r3 ; sub r4,r3,r1 -> EX forward on A
    drive("add3", 0, 1, 1, 1, 2, 3, 1, 0, 0);
    drive("sub",  0, 1, 1, 3, 1, 4, 1, 0, 0);
    drive("nop",  0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("nop",  0, 1, 0, 0, 0, 0, 0, 0, 0);
    // add r3 ; nop ; or rt=r3 -> MEM forward on B
    drive("add3b", 0, 1, 1, 1, 2, 3, 1, 0, 0);
    drive("nopb",  0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("or",    0, 1, 1, 6, 3, 8, 1, 0, 0);
    drive("nop",   0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("nop",   0, 1, 0, 0, 0, 0, 0, 0, 0);
    // lw r5 ; add rs=r5 -> one stall, then MEM forward
    drive("lw5",    0, 1, 1, 9, 0, 5, 1, 1, 0);
    drive("use5st", 0, 1, 1, 5, 2, 10, 1, 0, 0);
    drive("use5",   0, 1, 1, 5, 2, 10, 1, 0, 0);
    drive("nop",    0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("nop",    0, 1, 0, 0, 0, 0, 0, 0, 0);
    // r0 never forwards or stalls
    drive("addi0", 0, 1, 1, 1, 0, 0, 1, 0, 0);
    drive("use0",  0, 1, 1, 0, 0, 11, 1, 0, 0);
    drive("lw0",   0, 1, 1, 1, 0, 0, 1, 1, 0);
    drive("use0l", 0, 1, 1, 0, 0, 12, 1, 0, 0);
    drive("nop",   0, 1, 0, 0, 0, 0, 0, 0, 0);
    // lw r7 ; use r7 with flush -> no stall, bubble
    drive("lw7",    0, 1, 1, 1, 0, 7, 1, 1, 0);
    drive("use7fl", 0, 1, 1, 7, 7, 13, 1, 0, 1);
    // enable low holds selects and entries (stall_o still combinational)
    drive("add9",  0, 1, 1, 1, 2, 9, 1, 0, 0);
    drive("hold0", 0, 0, 1, 9, 9, 14, 1, 0, 0);
    drive("hold1", 0, 0, 1, 9, 9, 14, 1, 0, 0);
    drive("use9",  0, 1, 1, 9, 9, 14, 1, 0, 0);
    drive("lw11",  0, 1, 1, 1, 2, 11, 1, 1, 0);
    drive("hz_dis",0, 0, 1, 2, 11, 15, 1, 0, 0);
    // reset mid-stream with enable low
    drive("rst_dis", 1, 0, 1, 2, 11, 15, 1, 0, 0);
    drive("post_rst",0, 1, 1, 2, 11, 15, 1, 0, 0);
    // randomized stream; stalled instruction is held in ID like a real pipeline
    rs = 0; rt = 0; rd = 0; v = 0; rw = 0; mr = 0;
    for (k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 7) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      if (!last_stall) begin
        v  = ($urandom_range(0, 5) != 0);
        rs = $urandom_range(0, 5);
        rt = $urandom_range(0, 5);
        rd = $urandom_range(0, 5);
        rw = ($urandom_range(0, 4) != 0);
        mr = rw && ($urandom_range(0, 2) == 0);
      end
      drive("rand", rst, en, v, rs, rt, rd, rw, mr, fl);
    end
    drive("tail", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clock_i);
      k++;
    end
    repeat (2) @(posedge clock_i);
    chk("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
